// File: rtl/gtx_comp_fiber_tx_framer.sv
// gtx_comp_fiber_tx_framer
//   Transmit-side framer for the comparator fiber link. Each bunch crossing
//   (four clock_4x cycles) one 48-bit comparator word is sent as a K-char
//   header followed by three 16-bit data words. Also generates the start
//   pattern after enable, the periodic latency marker (with resync and
//   forced-error suppression) and PRBS-15 test data.
//
// Ports
//   clock_4x     in   160 MHz TX user clock
//   rst_n        in   asynchronous active-low reset
//   tx_enable    in   1 = run link, 0 = idle frames
//   ttc_resync   in   restart marker count; next frame carries the marker
//   prbs_en      in   send PRBS-15 words instead of comparator data
//   force_error  in   pulse: suppress the next scheduled marker
//   comp_dat     in   comparator data, sampled when data_taken=1
//   data_taken   out  high on the cycle whose rising edge samples comp_dat
//   txdata       out  GTX TXDATA
//   txcharisk    out  GTX TXCHARISK ([0] = low byte is K)
//   tx_word_idx  out  index 0..3 of the word on txdata
//   tx_state     out  0 IDLE, 1 START, 2 RUN
//   marker_sent  out  high while the marker header is on txdata
module gtx_comp_fiber_tx_framer #(
    parameter int unsigned START_FRAMES  = 8,
    parameter logic [47:0] START_PATTERN = 48'h5555AAAA55AA,
    parameter int unsigned MARKER_PERIOD = 128,
    parameter logic [14:0] PRBS_SEED     = 15'h7FFF
) (
    input  logic        clock_4x,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic        ttc_resync,
    input  logic        prbs_en,
    input  logic        force_error,
    input  logic [47:0] comp_dat,
    output logic        data_taken,
    output logic [15:0] txdata,
    output logic [1:0]  txcharisk,
    output logic [1:0]  tx_word_idx,
    output logic [1:0]  tx_state,
    output logic        marker_sent
);

    localparam int unsigned    MW         = $clog2(MARKER_PERIOD);
    localparam int unsigned    SCW        = $clog2(START_FRAMES) + 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_FRAMES - 1);
    localparam logic [15:0]    HDR_COMMA  = 16'h50BC;
    localparam logic [15:0]    HDR_MARKER = 16'h50FC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // 16 PRBS-15 steps (x^15+x^14+1); first generated bit lands in the MSB.
    // Returns {word, next_state}.
    function automatic logic [30:0] prbs16(input logic [14:0] seed);
        logic [14:0] s;
        logic [15:0] w;
        logic        fb;
        s = seed;
        w = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = s[14] ^ s[13];
            s  = {s[13:0], fb};
            w  = {w[14:0], fb};
        end
        return {w, s};
    endfunction

    function automatic logic [15:0] word_sel(input logic [47:0] d, input logic [1:0] p);
        case (p)
            2'd0:    return d[15:0];
            2'd1:    return d[31:16];
            default: return d[47:32];
        endcase
    endfunction

    logic [1:0]     ph_q, ph_d;
    state_t         state_q, state_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [MW-1:0]  mcnt_q, mcnt_d, mcnt_used;
    logic           resync_q, resync_d;
    logic           ferr_q, ferr_d;
    logic [47:0]    hold_q, hold_d;
    logic [14:0]    lfsr_q, lfsr_d, lfsr_base;
    logic           prbs_en_q, prbs_en_d;
    logic [30:0]    prbs_next;
    logic [15:0]    txdata_q, txdata_d;
    logic [1:0]     txk_q, txk_d;
    logic           mark_q, mark_d;
    logic           due;

    always_comb begin
        ph_d      = ph_q + 2'd1;
        state_d   = state_q;
        scnt_d    = scnt_q;
        mcnt_d    = mcnt_q;
        resync_d  = resync_q | ttc_resync;
        ferr_d    = ferr_q | force_error;
        hold_d    = hold_q;
        prbs_en_d = prbs_en;
        // A rising prbs_en restarts the sequence from the seed on this edge.
        lfsr_base = (prbs_en && !prbs_en_q) ? PRBS_SEED : lfsr_q;
        prbs_next = prbs16(lfsr_base);
        lfsr_d    = lfsr_base;
        txdata_d  = txdata_q;
        txk_d     = txk_q;
        mark_d    = 1'b0;
        mcnt_used = resync_d ? '0 : mcnt_q;
        due       = 1'b0;

        if (ph_q == 2'd3) begin
            // Frame boundary: capture data, pick state and header of next frame.
            hold_d = comp_dat;
            if (!tx_enable) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_START;
                        scnt_d  = '0;
                    end
                    ST_START: begin
                        if (scnt_q == START_LAST) state_d = ST_RUN;
                        else                      scnt_d  = scnt_q + SCW'(1);
                    end
                    default: state_d = ST_RUN;
                endcase
            end
            mcnt_d   = mcnt_used + MW'(1);
            resync_d = 1'b0;
            due      = (mcnt_used == '0) && (state_d == ST_RUN);
            if (due) ferr_d = 1'b0;
            mark_d   = due && !(ferr_q | force_error);
            txdata_d = mark_d ? HDR_MARKER : HDR_COMMA;
            txk_d    = 2'b01;
        end else begin
            txk_d = 2'b00;
            case (state_q)
                ST_START: txdata_d = word_sel(START_PATTERN, ph_q);
                ST_RUN: begin
                    if (prbs_en) begin
                        txdata_d = prbs_next[30:15];
                        lfsr_d   = prbs_next[14:0];
                    end else begin
                        txdata_d = word_sel(hold_q, ph_q);
                    end
                end
                default: txdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock_4x or negedge rst_n) begin
        if (!rst_n) begin
            ph_q      <= '0;
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            mcnt_q    <= '0;
            resync_q  <= 1'b0;
            ferr_q    <= 1'b0;
            hold_q    <= '0;
            lfsr_q    <= PRBS_SEED;
            prbs_en_q <= 1'b0;
            txdata_q  <= HDR_COMMA;
            txk_q     <= 2'b01;
            mark_q    <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            mcnt_q    <= mcnt_d;
            resync_q  <= resync_d;
            ferr_q    <= ferr_d;
            hold_q    <= hold_d;
            lfsr_q    <= lfsr_d;
            prbs_en_q <= prbs_en_d;
            txdata_q  <= txdata_d;
            txk_q     <= txk_d;
            mark_q    <= mark_d;
        end
    end

    assign data_taken  = (ph_q == 2'd3);
    assign txdata      = txdata_q;
    assign txcharisk   = txk_q;
    assign tx_word_idx = ph_q;
    assign tx_state    = state_q;
    assign marker_sent = mark_q;

endmodule
